// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, bit-serial shifts and a shift-add multiplier.
// IDLE accepts a request, BUSY iterates shifts/multiply, DONE holds the result until it is consumed.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_MOVB = 4'd0;
    localparam logic [3:0] OP_MOVA = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SAR  = 4'd11;
    localparam logic [3:0] OP_MINU = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    logic [1:0]       state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] hi;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_err;
    logic [3:0]       sc_flags;
    logic [CW-1:0]    shamt;
    logic             is_shift;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo;

    // Handshake: a request transfers on a rising edge with in_valid && in_ready; a result
    // transfers on a rising edge with out_valid && out_ready. in_ready is high only in IDLE,
    // out_valid only in DONE, so a new request can never overlap an undelivered result.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    assign shamt    = b[CW-1:0];
    assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (op)
            OP_MOVB: sc_res = b;
            OP_MOVA: sc_res = a;
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   sc_res = a | b;
            OP_AND:  sc_res = a & b;
            OP_XOR:  sc_res = a ^ b;
            OP_XNOR: sc_res = ~(a ^ b);
            OP_NOT:  sc_res = ~a;
            // Zero-length shift completes immediately with the operand unchanged.
            OP_SHL, OP_SHR, OP_SAR: sc_res = a;
            OP_MINU: sc_res = (a < b) ? a : b;
            OP_MUL:  sc_res = '0;
            default: sc_err = 1'b1;
        endcase
    end

    assign sc_flags = sc_err ? 4'b0000 : {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};

    always_comb begin
        sh_next = a_r;
        sh_out  = 1'b0;
        case (op_r)
            OP_SHL: begin
                sh_next = {a_r[WIDTH-2:0], 1'b0};
                sh_out  = a_r[WIDTH-1];
            end
            OP_SHR: begin
                sh_next = {1'b0, a_r[WIDTH-1:1]};
                sh_out  = a_r[0];
            end
            OP_SAR: begin
                sh_next = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
                sh_out  = a_r[0];
            end
            default: ;
        endcase
    end

    // {hi, b_r} is the product register; the multiplier is consumed from b_r's LSB.
    assign mul_sum = {1'b0, hi} + (b_r[0] ? {1'b0, a_r} : '0);
    assign mul_lo  = {mul_sum[0], b_r[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            hi     <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        hi   <= '0;
                        if (op == OP_MUL) begin
                            cnt   <= CW'(WIDTH - 1);
                            state <= BUSY;
                        end else if (is_shift && (shamt != '0)) begin
                            cnt   <= shamt - CW'(1);
                            state <= BUSY;
                        end else begin
                            result <= sc_res;
                            flags  <= sc_flags;
                            err    <= sc_err;
                            state  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (op_r == OP_MUL) begin
                        hi  <= mul_sum[WIDTH:1];
                        b_r <= mul_lo;
                    end else begin
                        a_r <= sh_next;
                    end
                    if (cnt == '0) begin
                        state <= DONE;
                        err   <= 1'b0;
                        if (op_r == OP_MUL) begin
                            result <= mul_lo;
                            flags  <= {mul_lo[WIDTH-1], (mul_lo == '0), (|mul_sum[WIDTH:1]), 1'b0};
                        end else begin
                            result <= sh_next;
                            flags  <= {sh_next[WIDTH-1], (sh_next == '0), sh_out, 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard of expected results/latencies against a behavioural model,
// plus directed vectors, reset abort, back-to-back requests and a 32-bit shift.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;
    logic [1:0]  state_dbg;

    logic        in_valid32;
    logic        in_ready32;
    logic [3:0]  op32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        out_valid32;
    logic        out_ready32;
    logic [31:0] result32;
    logic [3:0]  flags32;
    logic        err32;
    logic [1:0]  state_dbg32;

    logic [20:0] exp_q[$];
    int          lat_q[$];
    int          n_vec;
    int          n_miss;
    logic [15:0] last_res;
    logic [3:0]  last_flags;
    logic        last_err;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .err(err), .state_dbg(state_dbg)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
        .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32), .result(result32),
        .flags(flags32), .err(err32), .state_dbg(state_dbg32)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: {err, N, Z, C, V, result}
    function automatic logic [20:0] model(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] r;
        logic        c;
        logic        v;
        int          n;
        n = int'(xb[3:0]);
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            4'd0: r = xb;
            4'd1: r = xa;
            4'd2: begin
                w = {1'b0, xa} + {1'b0, xb};
                r = w[15:0];
                c = w[16];
                v = (xa[15] == xb[15]) && (r[15] != xa[15]);
            end
            4'd3: begin
                w = {1'b0, xa} - {1'b0, xb};
                r = w[15:0];
                c = (xa < xb);
                v = (xa[15] != xb[15]) && (r[15] != xa[15]);
            end
            4'd4: r = xa | xb;
            4'd5: r = xa & xb;
            4'd6: r = xa ^ xb;
            4'd7: r = ~(xa ^ xb);
            4'd8: r = ~xa;
            4'd9: begin
                r = xa << n;
                c = (n != 0) ? xa[16-n] : 1'b0;
            end
            4'd10: begin
                r = xa >> n;
                c = (n != 0) ? xa[n-1] : 1'b0;
            end
            4'd11: begin
                r = $signed(xa) >>> n;
                c = (n != 0) ? xa[n-1] : 1'b0;
            end
            4'd12: r = (xa < xb) ? xa : xb;
            4'd13: begin
                p = {16'h0000, xa} * {16'h0000, xb};
                r = p[15:0];
                c = |p[31:16];
            end
            default: return {1'b1, 4'b0000, 16'h0000};
        endcase
        return {1'b0, r[15], (r == 16'h0000), c, v, r};
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [15:0] xb);
        if (o == 4'd13) return 17;
        if (o >= 4'd9 && o <= 4'd11) return int'(xb[3:0]) + 1;
        return 1;
    endfunction

    // driver: issue one request, wait for the result, compare against the scoreboard, then consume it
    task automatic apply(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb, input int hold);
        logic [20:0] e;
        int          lat;
        int          cyc;
        exp_q.push_back(model(o, xa, xb));
        lat_q.push_back(exp_lat(o, xb));
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL ready_before_accept: got %b want 1", in_ready);
        end
        in_valid  = 1'b1;
        op        = o;
        a         = xa;
        b         = xb;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom_range(0, 15));
        a        = 16'($urandom);
        b        = 16'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 64);
        e   = exp_q.pop_front();
        lat = lat_q.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || cyc != lat) begin
            n_miss++;
            $display("FAIL latency op=%0d: got %0d cycles (out_valid=%b) want %0d", o, cyc, out_valid, lat);
        end
        n_vec++;
        if (result !== e[15:0] || flags !== e[19:16] || err !== e[20]) begin
            n_miss++;
            $display("FAIL result op=%0d a=%h b=%h: got res=%h flags=%b err=%b want res=%h flags=%b err=%b",
                     o, xa, xb, result, flags, err, e[15:0], e[19:16], e[20]);
        end
        last_res   = result;
        last_flags = flags;
        last_err   = err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== last_res || flags !== last_flags) begin
                n_miss++;
                $display("FAIL hold cycle %0d: got ov=%b ir=%b res=%h flags=%b want ov=1 ir=0 res=%h flags=%b",
                         i, out_valid, in_ready, result, flags, last_res, last_flags);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        op = 4'd2;
        a = 16'h0001;
        b = 16'h0001;
        out_ready = 1'b0;
        in_valid32 = 1'b0;
        op32 = '0;
        a32 = '0;
        b32 = '0;
        out_ready32 = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || flags !== 4'h0 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: got ir=%b ov=%b res=%h flags=%b err=%b want 1 0 0000 0000 0",
                     in_ready, out_valid, result, flags, err);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_spec_vectors();
        apply(4'd2, 16'hFFFF, 16'h0001, 0);
        n_vec++;
        if (last_res !== 16'h0000 || last_flags !== 4'b0110) begin
            n_miss++;
            $display("FAIL add_wrap: got res=%h flags=%b want res=0000 flags=0110", last_res, last_flags);
        end
        apply(4'd3, 16'h8000, 16'h0001, 0);
        n_vec++;
        if (last_res !== 16'h7FFF || last_flags !== 4'b0001) begin
            n_miss++;
            $display("FAIL sub_ovf: got res=%h flags=%b want res=7fff flags=0001", last_res, last_flags);
        end
        apply(4'd11, 16'h8004, 16'h0003, 0);
        n_vec++;
        if (last_res !== 16'hF000 || last_flags !== 4'b1010) begin
            n_miss++;
            $display("FAIL sar: got res=%h flags=%b want res=f000 flags=1010", last_res, last_flags);
        end
        apply(4'd13, 16'h0100, 16'h0101, 5);
        n_vec++;
        if (last_res !== 16'h0100 || last_flags !== 4'b0010) begin
            n_miss++;
            $display("FAIL mul: got res=%h flags=%b want res=0100 flags=0010", last_res, last_flags);
        end
        apply(4'd9, 16'h1234, 16'h0000, 1);
        n_vec++;
        if (last_res !== 16'h1234 || last_flags !== 4'b0000) begin
            n_miss++;
            $display("FAIL shift_zero: got res=%h flags=%b want res=1234 flags=0000", last_res, last_flags);
        end
    endtask

    task automatic test_all_ops();
        for (int o = 0; o < 16; o++)
            apply(4'(o), 16'($urandom), 16'($urandom), 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            apply(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), $urandom_range(0, 2));
    endtask

    task automatic test_reset_abort();
        int seen;
        apply(4'd14, 16'h5555, 16'hAAAA, 0);
        n_vec++;
        if (last_err !== 1'b1 || last_res !== 16'h0000 || last_flags !== 4'b0000) begin
            n_miss++;
            $display("FAIL illegal_op: got err=%b res=%h flags=%b want err=1 res=0000 flags=0000",
                     last_err, last_res, last_flags);
        end
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd13;
        a = 16'h00FF;
        b = 16'h00FF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000) begin
            n_miss++;
            $display("FAIL abort_in_reset: got ir=%b ov=%b res=%h want ir=1 ov=0 res=0000",
                     in_ready, out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL abort_release_ready: got %b want 1", in_ready);
        end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_miss++;
            $display("FAIL abort_no_result: got %0d out_valid cycles want 0", seen);
        end
        apply(4'd2, 16'd2, 16'd3, 0);
        n_vec++;
        if (last_res !== 16'd5) begin
            n_miss++;
            $display("FAIL add_after_abort: got %h want 0005", last_res);
        end
    endtask

    task automatic test_back_to_back();
        int   nres;
        logic prev;
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd2;
        a = 16'h1234;
        b = 16'h0F0F;
        out_ready = 1'b1;
        nres = 0;
        prev = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_vec++;
            if (out_valid === in_ready || (prev && out_valid)) begin
                n_miss++;
                $display("FAIL b2b_overlap: got ov=%b ir=%b prev_ov=%b want ov=!ir and no consecutive ov",
                         out_valid, in_ready, prev);
            end
            if (out_valid === 1'b1) begin
                nres++;
                n_vec++;
                if (result !== 16'h2143) begin
                    n_miss++;
                    $display("FAIL b2b_result: got %h want 2143", result);
                end
            end
            prev = out_valid;
        end
        n_vec++;
        if (nres != 5) begin
            n_miss++;
            $display("FAIL b2b_count: got %0d results want 5", nres);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_w32();
        int cyc;
        @(negedge clk);
        in_valid32 = 1'b1;
        op32 = 4'd9;
        a32 = 32'h0000_0001;
        b32 = 32'd31;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        b32 = 32'd1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (out_valid32 !== 1'b1 && cyc < 64);
        n_vec++;
        if (out_valid32 !== 1'b1 || cyc != 32) begin
            n_miss++;
            $display("FAIL w32_latency: got %0d cycles want 32", cyc);
        end
        n_vec++;
        if (result32 !== 32'h8000_0000 || flags32 !== 4'b1000 || err32 !== 1'b0) begin
            n_miss++;
            $display("FAIL w32_shl: got res=%h flags=%b err=%b want res=80000000 flags=1000 err=0",
                     result32, flags32, err32);
        end
        out_ready32 = 1'b1;
        @(posedge clk);
        #1;
        out_ready32 = 1'b0;
        n_vec++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            n_miss++;
            $display("FAIL w32_release: got ov=%b ir=%b want ov=0 ir=1", out_valid32, in_ready32);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_spec_vectors();
        test_all_ops();
        test_random();
        test_reset_abort();
        test_back_to_back();
        test_w32();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
